// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and defaults for the MAC result drain
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } drain_state_t;

    localparam int ACC_W_DEF = 32;
    localparam int OUT_W_DEF = 16;
    localparam int M_DEF     = 4;

    function automatic int beat_count(input int m);
        return m * m;
    endfunction

endpackage

// File: rtl/acc_saturate.sv
// rtl/acc_saturate.sv - ACC_W to OUT_W element converter
// MAC_DRAIN_SAT_EN selects signed saturation; otherwise low OUT_W bits are kept.
module acc_saturate
#(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
)(
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] out_o
);

`ifdef MAC_DRAIN_SAT_EN
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        if (acc_i > MAX_V) begin
            out_o = MAX_V[OUT_W-1:0];
        end else if (acc_i < MIN_V) begin
            out_o = MIN_V[OUT_W-1:0];
        end else begin
            out_o = acc_i[OUT_W-1:0];
        end
    end
`else
    logic unused_hi;

    // Upper accumulator bits are intentionally discarded by truncation.
    assign unused_hi = ^acc_i;
    assign out_o     = acc_i[OUT_W-1:0];
`endif

endmodule

// File: rtl/mac_result_drain.sv
// rtl/mac_result_drain.sv - snapshot the MxM accumulators and stream them out row-major
// Element conversion is selected by MAC_DRAIN_SAT_EN inside acc_saturate.
module mac_result_drain
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int M     = M_DEF
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [ACC_W-1:0] acc [M][M],
    output logic                    busy,
    output logic                    mac_clear,
    output logic                    done,
    output logic signed [OUT_W-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
);

    localparam int BEATS = beat_count(M);
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    drain_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic capture;

    // Flattened row-major snapshot, so the beat index addresses it directly.
    logic signed [ACC_W-1:0] snap_q [BEATS];
    logic signed [ACC_W-1:0] sel_acc;
    logic signed [OUT_W-1:0] conv;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < M; j++) begin
                    snap_q[i*M + j] <= acc[i][j];
                end
            end
        end
    end

    assign sel_acc = snap_q[idx_q];

    acc_saturate #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_conv (
        .acc_i (sel_acc),
        .out_o (conv)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        capture       = 1'b0;
        busy          = 1'b0;
        mac_clear     = 1'b0;
        done          = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                busy          = 1'b1;
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = conv;
                m_axis_tlast  = (idx_q == LAST_IDX);
                if (m_axis_tready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                mac_clear = 1'b1;
                done      = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mac_result_drain.md
# mac_result_drain

Result read-out engine for the MAC array. On a start pulse it snapshots the full M×M accumulator matrix and streams it out row-major as an AXI4-Stream master, one element per beat. After the last beat it issues a one-cycle clear to the array. It sits between the MAC array's `acc` outputs and the accelerator's output DMA/stream path, and is the read side of the array's accumulate/clear protocol.

## Interface

Parameters:
- `ACC_W`, default 32: accumulator width, signed.
- `OUT_W`, default 16: stream element width, signed. Must satisfy `OUT_W <= ACC_W`.
- `M`, default 4: matrix dimension. The stream carries M*M beats.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: capture-and-drain request pulse.
- `acc`, input, signed [ACC_W-1:0] [M][M]: accumulator matrix from the MAC array.
- `busy`, output, 1: high from the capture cycle through the DONE state.
- `mac_clear`, output, 1: one-cycle clear pulse to the MAC array.
- `done`, output, 1: one-cycle completion pulse, coincident with `mac_clear`.
- `m_axis_tdata`, output, signed [OUT_W-1:0]: element data.
- `m_axis_tvalid`, output, 1: AXIS valid.
- `m_axis_tready`, input, 1: AXIS ready.
- `m_axis_tlast`, output, 1: asserted on beat M*M-1.

## Operation

- States: `IDLE`, `STREAM`, `DONE`.
- **IDLE**
  - On `start`, register all of `acc` into the snapshot array, reset the beat index to 0, and go to `STREAM`.
  - `start` is ignored in every other state.
- **STREAM**
  - `m_axis_tvalid` = 1.
  - `m_axis_tdata` = convert(snapshot[idx / M][idx % M]).
  - `m_axis_tlast` = (idx == M*M-1).
  - On each handshake (`tvalid && tready`), idx increments.
  - The handshake on idx == M*M-1 moves the FSM to `DONE`.
- **DONE**: one cycle only. `mac_clear` = 1, `done` = 1, `tvalid` = 0. Next state is `IDLE`.
- AXIS rules:
  - Once `tvalid` is high it stays high, and `tdata`/`tlast` stay stable, until the handshake.
  - `tvalid` does not depend combinationally on `tready`.
- The snapshot isolates the stream from changes on `acc` after capture. The array may keep running, but its results are lost at `mac_clear`.
- Conversion from ACC_W to OUT_W is set by the macro in Configuration. When OUT_W == ACC_W it is an identity.
- Reset, including mid-stream:
  - All outputs go to 0 in the cycle after `rst` is sampled: `tvalid`, `tdata`, `tlast`, `busy`, `mac_clear`, `done`.
  - FSM returns to `IDLE` and idx returns to 0.
  - No `mac_clear` is issued for an aborted drain.

## Timing

- `start` sampled at edge N: snapshot is taken at edge N, and `busy` and `tvalid` are high from cycle N+1.
- With `tready` held high:
  - Beats complete on cycles N+1 through N+M*M.
  - `tlast` is high on cycle N+M*M.
  - `DONE`, `mac_clear` and `done` fall on cycle N+M*M+1.
  - `busy` is low from N+M*M+2.
- Throughput is one beat per cycle, with no bubbles between beats.
- Minimum spacing between accepted `start` pulses is M*M+2 cycles.
- A `start` on the `DONE` cycle is ignored. A `start` in the first `IDLE` cycle is accepted.
- Backpressure stretches `STREAM` by the number of `tready`-low cycles, with no data loss or reordering.

## Configuration

- `MAC_DRAIN_SAT_EN` defined: signed saturation.
  - Values above 2^(OUT_W-1)-1 clamp to that maximum.
  - Values below -2^(OUT_W-1) clamp to that minimum.
- `MAC_DRAIN_SAT_EN` undefined: plain truncation to the low OUT_W bits.
- The macro has no effect on timing or interface.

## Structure

- Package `mac_pkg`:
  - Drain state enum `drain_state_t` {IDLE, STREAM, DONE}.
  - Default widths `ACC_W_DEF`, `OUT_W_DEF`, `M_DEF`.
  - Function or constant for the beat count M*M.
- Sub-module `acc_saturate`, parameterised on ACC_W and OUT_W: a combinational converter holding the macro-selected saturate/truncate logic. It is instantiated once, on the snapshot read mux output.

## Test plan

- Counting drain: acc[i][j] = 4i+j, `tready` = 1, pulse `start`.
  - Expect 16 beats, values 0..15, in consecutive cycles.
  - `tlast` only on value 15.
  - `mac_clear`/`done` pulse exactly one cycle later.
- Backpressure: same data, `tready` alternating 1/0 and then low for 5 cycles at beat 7.
  - Data and `tlast` stable while stalled.
  - Order is 0..15 with no duplicates.
  - `DONE` follows the last handshake.
- Snapshot and ignored start:
  - Change all `acc` values to 99 one cycle after `start`: all 16 beats still carry the original values.
  - A `start` pulse during `STREAM` and on the `DONE` cycle produces no second drain.
- Width conversion: acc[0][0] = 100000, acc[0][1] = -70000, acc[0][2] = -5.
  - With `MAC_DRAIN_SAT_EN`: 32767, -32768, -5.
  - Without it: 0x86A0, 0xEE90, -5 (0xFFFB).
- Reset mid-stream: assert `rst` at beat 5.
  - `tvalid`, `busy` and `tdata` are 0 on the next cycle.
  - No `mac_clear` pulse.
  - A subsequent `start` drains again from beat 0.
